elevator_ctrl_n: RTL and testbench
==================================

// Module: elevator_ctrl_n
// PURPOSE
//  Parametrised N-floor elevator controller; successor to the fixed 3-floor movement FSM.
//  Inputs: interior and exterior call panels, sampled synchronously.
//  Requests are latched per floor and served in SCAN order: keep direction while calls lie ahead.
//  Drives engine command and per-floor door outputs; timed door dwell and timed inter-floor travel.
// PARAMETERS
//  FLOORS         4   number of floors, >=2; floor 0 is ground
//  DOOR_CYCLES    8   clock cycles doors stay open after an arrival, >=1
//  TRAVEL_CYCLES  4   clock cycles to move one floor, >=1
//  FW             $clog2(FLOORS)  floor index width (localparam)
// PORTS
//  CLK             in   1       rising-edge clock
//  RST             in   1       asynchronous reset, active-low
//  interior_panel  in   FLOORS  car buttons, bit i = floor i, synchronous to CLK
//  exterior_panel  in   FLOORS  hall buttons, bit i = floor i, synchronous to CLK
//  engine          out  2       00 off, 10 up, 11 down
//  doors           out  FLOORS  one-hot open door; all 0 = closed
//  floor           out  FW      current or last-passed floor
//  direction       out  1       1 up, 0 down
//  pending         out  FLOORS  latched unserved requests
// BEHAVIOUR
//  Reset (async, RST=0): state IDLE, floor=0, direction=1, engine=00, doors=1 (floor 0 open),
//   pending=0, edge registers=0, counters=0. Reset mid-travel abandons the trip; no recovery of position.
//  Request capture:
//   - call[i] = rising edge of (interior_panel[i] | exterior_panel[i]), from a 1-cycle delayed copy.
//   - pending[i] sets the cycle after the edge is sampled.
//   - A held button gives one request only.
//   - Call at current floor in IDLE: ignored, door already open.
//   - Call at current floor in DOOR_OPEN: not latched; reloads dwell counter to DOOR_CYCLES-1.
//   - Any call in MOVE_UP/MOVE_DOWN is latched, including the floor just left.
//   - Set and clear of the same bit in one cycle: clear wins.
//  FSM (registered outputs):
//   IDLE: engine=00, doors=onehot(floor). If pending!=0, direction is chosen:
//     - up if direction=1 and a call lies above;
//     - else down if a call lies below;
//     - else up.
//     Next cycle: state MOVE_UP/MOVE_DOWN, doors=0, engine=10/11, travel counter=TRAVEL_CYCLES-1.
//   MOVE_x: travel counter decrements each cycle. At 0, floor+=1 (up) or -=1 (down). Then:
//     - If pending[new floor]: go to DOOR_OPEN, engine=00, doors=onehot(new floor),
//       clear pending[new floor], dwell counter=DOOR_CYCLES-1.
//     - Else: reload travel counter and continue.
//     Floor never leaves [0,FLOORS-1]: motion starts only toward a pending call.
//   DOOR_OPEN: engine=00, doors open; dwell decrements; at 0 -> IDLE with doors still open.
//  Latency: call edge at cycle t -> pending at t+1 -> engine on at t+2 (from IDLE).
//   Arrival after k floors is TRAVEL_CYCLES*k cycles in MOVE.
//  Engine and doors never active together: doors=0 whenever engine!=00.
// STRUCTURE
//  elevator_pkg:
//   - engine codes ENG_OFF=2'b00, ENG_UP=2'b10, ENG_DN=2'b11
//   - state typedef {IDLE, DOOR_OPEN, MOVE_UP, MOVE_DOWN}
//  Sub-module elevator_req_latch #(FLOORS):
//   - edge detect, OR of both panels, pending register with set/clear ports
//  Top holds the FSM, floor/direction registers, travel and dwell counters, and the SCAN
//   above/below reduction (mask pending by floor index).
// TESTING (FLOORS=4, DOOR_CYCLES=3, TRAVEL_CYCLES=2)
//  1 Reset mid-MOVE_UP, RST low 1 cycle
//    -> engine=00, doors=0001, floor=0, pending=0000 immediately (async).
//  2 After reset, pulse interior_panel=0100 at t
//    -> pending=0100 at t+1; engine=10, doors=0000 at t+2; floor=1 at t+4, floor=2 at t+6;
//       doors=0100, engine=00, pending=0000 at t+6.
//  3 At floor 2 moving up, latch calls 0001 and 1000
//    -> serves floor 3 first (SCAN), then reverses: direction=0, stops at floor 0;
//       never stops at floors 1/2.
//  4 Hold exterior_panel[1] high 20 cycles while at floor 0
//    -> exactly one request; one trip to floor 1.
//  5 In DOOR_OPEN at floor 2, press floor 2 each 2 cycles
//    -> dwell keeps reloading, door stays open, no latch.
//    After release -> IDLE after 3 cycles.
//  6 Press floor 1 and floor 3 in the same cycle from floor 0
//    -> stops at floor 1 (dwell 3), then floor 3.
//    Throughout, assert engine!=00 implies doors==0, and doors is one-hot or zero.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared engine command codes and controller state encoding for the SCAN elevator.
package elevator_pkg;

    localparam logic [1:0] ENG_OFF = 2'b00;
    localparam logic [1:0] ENG_UP  = 2'b10;
    localparam logic [1:0] ENG_DN  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t DOOR_OPEN = 2'd1;
    localparam state_t MOVE_UP   = 2'd2;
    localparam state_t MOVE_DOWN = 2'd3;

endpackage

// File: rtl/elevator_req_latch.sv
// Per-floor call capture: rising edge of either panel, held in a pending register.
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int FLOORS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLOORS-1:0] interior_panel,
    input  logic [FLOORS-1:0] exterior_panel,
    input  logic [FLOORS-1:0] set_mask,
    input  logic [FLOORS-1:0] clr,
    output logic [FLOORS-1:0] call,
    output logic [FLOORS-1:0] pending
);

    logic [FLOORS-1:0] panel;
    logic [FLOORS-1:0] panel_q;

    assign panel = interior_panel | exterior_panel;
    assign call  = panel & ~panel_q;

    // Clear dominates so an arrival never leaves its own request behind.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            panel_q <= '0;
            pending <= '0;
        end else begin
            panel_q <= panel;
            pending <= (pending | (call & set_mask)) & ~clr;
        end
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: FSM, position/direction, travel and dwell timers.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | parked, door of current floor open, choosing next direction
//  DOOR_OPEN | just arrived, dwell timer running, door open
//  MOVE_UP   | engine up, travel timer counts down to next floor
//  MOVE_DOWN | engine down, travel timer counts down to next floor
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter  int FLOORS        = 4,
    parameter  int DOOR_CYCLES   = 8,
    parameter  int TRAVEL_CYCLES = 4,
    localparam int FW            = $clog2(FLOORS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLOORS-1:0] interior_panel,
    input  logic [FLOORS-1:0] exterior_panel,
    output logic [1:0]        engine,
    output logic [FLOORS-1:0] doors,
    output logic [FW-1:0]     floor,
    output logic              direction,
    output logic [FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LOAD  = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] ONE     = {{(FLOORS-1){1'b0}}, 1'b1};

    state_t            state;
    logic [TW-1:0]     travel_cnt;
    logic [DW-1:0]     dwell_cnt;

    logic [FLOORS-1:0] call;
    logic [FLOORS-1:0] set_mask;
    logic [FLOORS-1:0] clr;
    logic [FLOORS-1:0] floor_oh;
    logic [FLOORS-1:0] next_oh;
    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] below_mask;
    logic [FW-1:0]     next_floor;
    logic              moving;
    logic              call_above;
    logic              call_below;
    logic              arrive;
    logic              here_call;

    elevator_req_latch #(.FLOORS(FLOORS)) u_req (
        .CLK            (CLK),
        .RST            (RST),
        .interior_panel (interior_panel),
        .exterior_panel (exterior_panel),
        .set_mask       (set_mask),
        .clr            (clr),
        .call           (call),
        .pending        (pending)
    );

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
    end

    assign moving     = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign floor_oh   = ONE << floor;
    assign next_floor = (state == MOVE_UP) ? floor + 1'b1 : floor - 1'b1;
    assign next_oh    = ONE << next_floor;
    assign call_above = |(pending & above_mask);
    assign call_below = |(pending & below_mask);
    assign arrive     = moving && (travel_cnt == '0) && |(pending & next_oh);
    assign clr        = arrive ? next_oh : '0;
    // While parked or dwelling, the current floor is already served.
    assign set_mask   = moving ? '1 : ~floor_oh;
    assign here_call  = (state == DOOR_OPEN) && |(call & floor_oh);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            floor      <= '0;
            direction  <= 1'b1;
            engine     <= ENG_OFF;
            doors      <= ONE;
            travel_cnt <= '0;
            dwell_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    engine <= ENG_OFF;
                    doors  <= floor_oh;
                    // Keep heading up while calls remain above; otherwise serve below.
                    if (call_above && (direction || !call_below)) begin
                        state      <= MOVE_UP;
                        direction  <= 1'b1;
                        engine     <= ENG_UP;
                        doors      <= '0;
                        travel_cnt <= TRAVEL_LOAD;
                    end else if (call_below) begin
                        state      <= MOVE_DOWN;
                        direction  <= 1'b0;
                        engine     <= ENG_DN;
                        doors      <= '0;
                        travel_cnt <= TRAVEL_LOAD;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (travel_cnt == '0) begin
                        floor <= next_floor;
                        if (arrive) begin
                            state     <= DOOR_OPEN;
                            engine    <= ENG_OFF;
                            doors     <= next_oh;
                            dwell_cnt <= DWELL_LOAD;
                        end else begin
                            travel_cnt <= TRAVEL_LOAD;
                        end
                    end else begin
                        travel_cnt <= travel_cnt - 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (here_call) begin
                        dwell_cnt <= DWELL_LOAD;
                    end else if (dwell_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scoreboarded bench for elevator_ctrl_n: expected stop floors queued at call time.
module tb_elevator_ctrl_n;

    localparam int FL = 4;
    localparam int DC = 3;
    localparam int TC = 2;
    localparam logic [1:0] E_OFF = 2'b00;
    localparam logic [1:0] E_UP  = 2'b10;
    localparam logic [1:0] E_DN  = 2'b11;

    logic          CLK = 1'b0;
    logic          RST;
    logic [FL-1:0] interior_panel;
    logic [FL-1:0] exterior_panel;
    logic [1:0]    engine;
    logic [FL-1:0] doors;
    logic [1:0]    floor;
    logic          direction;
    logic [FL-1:0] pending;

    int n_vec    = 0;
    int n_err    = 0;
    int n_arrive = 0;
    int sb[$];
    int cur;
    logic [1:0] prev_eng = E_OFF;

    elevator_ctrl_n #(.FLOORS(FL), .DOOR_CYCLES(DC), .TRAVEL_CYCLES(TC)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .interior_panel (interior_panel),
        .exterior_panel (exterior_panel),
        .engine         (engine),
        .doors          (doors),
        .floor          (floor),
        .direction      (direction),
        .pending        (pending)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    // Runs until every queued stop was seen, then lets the dwell expire into IDLE.
    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || engine != E_OFF || pending != '0) && n < budget) begin
            step(1);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 0);
        chk("pending_drained", 32'(pending), 0);
        step(DC + 1);
    endtask

    task automatic wait_open(input logic [FL-1:0] d, input int budget);
        int n = 0;
        while (!(doors == d && engine == E_OFF) && n < budget) begin
            step(1);
            n++;
        end
        chk("open_reached", 32'(doors), 32'(d));
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            prev_eng = E_OFF;
        end else begin
            if (engine != E_OFF && doors != '0) chk("eng_door_excl", 32'(doors), 0);
            if (!$onehot0(doors)) chk("doors_onehot", 32'($countones(doors)), 1);
            if (prev_eng != E_OFF && engine == E_OFF) begin
                n_arrive++;
                if (sb.size() == 0) begin
                    chk("unexpected_stop", 32'(floor), 32'(FL));
                end else begin
                    int e;
                    e = sb.pop_front();
                    chk("stop_floor", 32'(floor), 32'(e));
                    chk("stop_doors", 32'(doors), 32'(1 << e));
                end
            end
            prev_eng = engine;
        end
    end

    initial begin
        int f;
        int base;
        int open;
        RST = 1'b0;
        interior_panel = '0;
        exterior_panel = '0;
        cur = 0;
        step(2);
        chk("rst_engine", 32'(engine), 32'(E_OFF));
        chk("rst_doors", 32'(doors), 32'h1);
        chk("rst_floor", 32'(floor), 0);
        chk("rst_dir", 32'(direction), 1);
        chk("rst_pending", 32'(pending), 0);
        RST = 1'b1;
        step(1);

        // reset while travelling up
        interior_panel = 4'b1000;
        step(1);
        interior_panel = '0;
        step(3);
        chk("t1_moving", 32'(engine), 32'(E_UP));
        RST = 1'b0;
        #1;
        chk("t1_engine", 32'(engine), 32'(E_OFF));
        chk("t1_doors", 32'(doors), 32'h1);
        chk("t1_floor", 32'(floor), 0);
        chk("t1_pending", 32'(pending), 0);
        sb.delete();
        step(1);
        RST = 1'b1;
        step(1);

        // latency of a single request to floor 2
        interior_panel = 4'b0100;
        sb.push_back(2);
        step(1);
        interior_panel = '0;
        chk("t2_pend_t1", 32'(pending), 32'h4);
        chk("t2_eng_t1", 32'(engine), 32'(E_OFF));
        step(1);
        chk("t2_eng_t2", 32'(engine), 32'(E_UP));
        chk("t2_doors_t2", 32'(doors), 0);
        step(2);
        chk("t2_floor_t4", 32'(floor), 1);
        chk("t2_eng_t4", 32'(engine), 32'(E_UP));
        step(2);
        chk("t2_floor_t6", 32'(floor), 2);
        chk("t2_doors_t6", 32'(doors), 32'h4);
        chk("t2_eng_t6", 32'(engine), 32'(E_OFF));
        chk("t2_pend_t6", 32'(pending), 0);

        // SCAN: floor 3 first, then straight down to 0
        interior_panel = 4'b1001;
        sb.push_back(3);
        sb.push_back(0);
        step(1);
        interior_panel = '0;
        chk("t3_pend", 32'(pending), 32'h9);
        wait_idle(200);
        chk("t3_floor", 32'(floor), 0);
        chk("t3_dir", 32'(direction), 0);
        cur = 0;

        // held hall button yields a single request
        base = n_arrive;
        exterior_panel = 4'b0010;
        sb.push_back(1);
        step(20);
        exterior_panel = '0;
        wait_idle(200);
        chk("t4_trips", 32'(n_arrive - base), 1);
        chk("t4_floor", 32'(floor), 1);
        cur = 1;

        // repeated presses at the open floor keep reloading the dwell
        interior_panel = 4'b0100;
        sb.push_back(2);
        step(1);
        interior_panel = '0;
        wait_open(4'b0100, 100);
        for (int k = 0; k < 4; k++) begin
            interior_panel = 4'b0100;
            step(1);
            interior_panel = '0;
            chk("t5_doors", 32'(doors), 32'h4);
            chk("t5_engine", 32'(engine), 32'(E_OFF));
            chk("t5_pending", 32'(pending), 0);
            step(1);
        end
        interior_panel = 4'b0101;
        sb.push_back(0);
        step(1);
        interior_panel = '0;
        chk("t5_pend0", 32'(pending), 32'h1);
        step(3);
        chk("t5_still_open", 32'(engine), 32'(E_OFF));
        chk("t5_still_doors", 32'(doors), 32'h4);
        step(1);
        chk("t5_depart", 32'(engine), 32'(E_DN));
        wait_idle(200);
        cur = 0;

        // two calls at once: stop at 1 with full dwell, then 3
        interior_panel = 4'b1010;
        sb.push_back(1);
        sb.push_back(3);
        step(1);
        interior_panel = '0;
        wait_open(4'b0010, 100);
        open = 0;
        while (engine == E_OFF && open < 100) begin
            step(1);
            open++;
        end
        chk("t6_dwell1", 32'(open), 32'(DC + 1));
        chk("t6_leave_up", 32'(engine), 32'(E_UP));
        wait_idle(200);
        chk("t6_floor", 32'(floor), 3);
        cur = 3;

        // call at the parked floor is ignored
        interior_panel = 4'(1 << cur);
        step(1);
        interior_panel = '0;
        step(2);
        chk("here_pending", 32'(pending), 0);
        chk("here_engine", 32'(engine), 32'(E_OFF));
        chk("here_doors", 32'(doors), 32'(1 << cur));

        // a few random single trips
        repeat (4) begin
            f = $urandom_range(0, FL - 1);
            while (f == cur) f = $urandom_range(0, FL - 1);
            if ($urandom_range(0, 1) == 1) interior_panel = 4'(1 << f);
            else exterior_panel = 4'(1 << f);
            sb.push_back(f);
            step(1);
            interior_panel = '0;
            exterior_panel = '0;
            wait_idle(200);
            chk("rnd_floor", 32'(floor), 32'(f));
            chk("rnd_dir", 32'(direction), 32'(f > cur));
            cur = f;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
